// File: rtl/mem_load_unit_pkg.sv
// Shared encodings for the load unit: load types, exception codes, FSM states.
// The alignment helper is only consulted when MEM_LOAD_ALIGN_CHECK_EN is defined.
package mem_load_unit_pkg;

  localparam logic [2:0] LD_NONE  = 3'd0;
  localparam logic [2:0] LD_WORD  = 3'd1;
  localparam logic [2:0] LD_HALF  = 3'd2;
  localparam logic [2:0] LD_HALFU = 3'd3;
  localparam logic [2:0] LD_BYTE  = 3'd4;
  localparam logic [2:0] LD_BYTEU = 3'd5;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_BUS  = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_misaligned(input logic [2:0] ld_type, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (ld_type == LD_WORD && off != 2'b00) bad = 1'b1;
    if ((ld_type == LD_HALF || ld_type == LD_HALFU) && off[0]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_unit_extract.sv
// load_extract: selects the addressed byte/halfword/word out of a raw memory
// word and zero- or sign-extends it to 32 bits. Purely combinational.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] rd_data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_data_i[{off_i, 3'b000} +: 8];
  // Halfword loads only look at off[1]; off[0] is an alignment concern, not a select.
  assign half_sel = off_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];

  // NOTE: every path assigns data_o, starting with a default, so no latch is inferred.
  always_comb begin
    data_o = '0;
    case (type_i)
      LD_WORD:  data_o = rd_data_i;
      LD_HALF:  data_o = {{16{half_sel[15]}}, half_sel};
      LD_HALFU: data_o = {16'h0000, half_sel};
      LD_BYTE:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BYTEU: data_o = {24'h000000, byte_sel};
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: accepts a load, waits for read data (with timeout),
// extracts/extends it and holds the result until writeback takes it.
// Optional misaligned-load (AdEL) detection: define MEM_LOAD_ALIGN_CHECK_EN.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_off,
  input  logic [2:0]  req_type,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        ld_valid,
  input  logic        ld_ready,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_exc,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       type_q, type_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       exc_q, exc_d;
  logic             valid_q, valid_d;

  logic        accept;
  logic        misalign;
  logic [1:0]  ext_off;
  logic [2:0]  ext_type;
  logic [31:0] ext_data;

  assign req_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && ld_ready);
  assign accept    = req_valid && req_ready && (req_type != LD_NONE);

`ifdef MEM_LOAD_ALIGN_CHECK_EN
  assign misalign = is_misaligned(req_type, req_off);
`else
  assign misalign = 1'b0;
`endif

  // One extractor serves both capture paths: live request in the accept
  // cycle, registered offset/type while waiting.
  assign ext_off  = (state_q == S_WAIT) ? off_q  : req_off;
  assign ext_type = (state_q == S_WAIT) ? type_q : req_type;

  load_extract u_extract (
    .rd_data_i (rd_data),
    .off_i     (ext_off),
    .type_i    (ext_type),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    type_d  = type_q;
    data_d  = data_q;
    exc_d   = exc_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (rd_valid) begin
          data_d  = ext_data;
          exc_d   = EXC_NONE;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          exc_d   = EXC_BUS;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ld_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A new accept (from IDLE, or from DONE as the result drains) overrides
    // the drain above so back-to-back loads see no bubble.
    if (accept) begin
      off_d  = req_off;
      type_d = req_type;
      if (misalign) begin
        data_d  = '0;
        exc_d   = EXC_ADEL;
        valid_d = 1'b1;
        state_d = S_DONE;
      end else if (rd_valid) begin
        data_d  = ext_data;
        exc_d   = EXC_NONE;
        valid_d = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = S_WAIT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      type_q  <= LD_NONE;
      data_q  <= '0;
      exc_q   <= EXC_NONE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      type_q  <= type_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
    end
  end

  assign ld_valid = valid_q;
  assign ld_data  = data_q;
  assign ld_exc   = exc_q;
  assign busy     = (state_q != S_IDLE);

endmodule
